// File: rtl/xmss_pkg.sv
// Shared XMSS definitions for the WOTS+ chaining controller.
//   - Winternitz parameter, hash padding prefixes and the message-length code.
//   - ADRS word offsets and a helper that overwrites one 32-bit ADRS word.
//   - Controller FSM state enum and the message-type selector for the formatter.
package xmss_pkg;

    localparam int W = 16;

    // toByte(PAD, 32) prefixes that select the keyed hash variant
    localparam logic [255:0] PAD_F   = 256'd0;
    localparam logic [255:0] PAD_PRF = 256'd3;

    // Hash core length code: 0 selects a 768-bit message
    localparam logic MSG_LEN_768 = 1'b0;

    // ADRS is 8 big-endian 32-bit words, word 0 in the most significant slot
    localparam int ADRS_WORDS     = 8;
    localparam int ADRS_HASH_WORD = 6;
    localparam int ADRS_KAM_WORD  = 7;

    // keyAndMask values for the two PRF calls of one chain step
    localparam logic [31:0] KAM_KEY  = 32'd0;
    localparam logic [31:0] KAM_MASK = 32'd1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_KEY_REQ  = 3'd1,
        ST_KEY_WAIT = 3'd2,
        ST_BM_REQ   = 3'd3,
        ST_BM_WAIT  = 3'd4,
        ST_F_REQ    = 3'd5,
        ST_F_WAIT   = 3'd6,
        ST_DONE     = 3'd7
    } chain_state_e;

    typedef enum logic [1:0] {
        MSG_NONE = 2'd0,
        MSG_PRF  = 2'd1,
        MSG_F    = 2'd2
    } msg_type_e;

    // Return adrs with 32-bit word number `word` replaced by `value`
    function automatic logic [255:0] adrs_set_word(input logic [255:0] adrs,
                                                   input int          word,
                                                   input logic [31:0] value);
        logic [255:0] res;
        res = adrs;
        res[(ADRS_WORDS - 1 - word) * 32 +: 32] = value;
        return res;
    endfunction

endpackage

// File: rtl/wots_msg_fmt.sv
// Combinational formatter for the 768-bit messages sent to the hash core.
//   msg_type_i     : MSG_PRF, MSG_F or MSG_NONE (MSG_NONE drives all zeros)
//   idx_i          : chain index written into ADRS word 6 (hashAddress)
//   key_and_mask_i : value written into ADRS word 7 for PRF calls
//   seed_i/adrs_i  : public seed and base OTS address
//   key_i/bm_i/tmp_i : key, bitmask and current chain value for F calls
//   hash_data_in_o : 1024-bit message bus, payload in [767:0], [1023:768] zero
module wots_msg_fmt
    import xmss_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  msg_type_e          msg_type_i,
    input  logic [IDX_W-1:0]   idx_i,
    input  logic [31:0]        key_and_mask_i,
    input  logic [255:0]       seed_i,
    input  logic [255:0]       adrs_i,
    input  logic [255:0]       key_i,
    input  logic [255:0]       bm_i,
    input  logic [255:0]       tmp_i,
    output logic [1023:0]      hash_data_in_o
);

    logic [255:0] adrs_prf_s;

    // ADRS' = adrs with hashAddress and keyAndMask overwritten
    always_comb begin
        adrs_prf_s = adrs_set_word(adrs_i, ADRS_HASH_WORD, 32'(idx_i));
        adrs_prf_s = adrs_set_word(adrs_prf_s, ADRS_KAM_WORD, key_and_mask_i);
    end

    // Message assembly; byte 0 of the message lands in [767:760]
    always_comb begin
        hash_data_in_o = 1024'd0;
        case (msg_type_i)
            MSG_PRF: hash_data_in_o = {256'd0, PAD_PRF, seed_i, adrs_prf_s};
            MSG_F:   hash_data_in_o = {256'd0, PAD_F, key_i, tmp_i ^ bm_i};
            default: hash_data_in_o = 1024'd0;
        endcase
    end

endmodule

// File: rtl/wots_chain_ctrl.sv
// WOTS+ chaining controller: computes c^s(x, i) by driving three hash calls
// per step (PRF key, PRF bitmask, F) into a sha256XMSS_with_sha256 core.
//   clk, reset            : clock, synchronous active-high reset
//   start, x_in, start_idx, steps, pub_seed, adrs : chain request
//   data_out, data_out_valid, done, busy           : chain result / status
//   hash_*  (out)         : request interface to the hash core
//   hash_data_out, hash_done, hash_busy (in)       : hash core response
module wots_chain_ctrl
    import xmss_pkg::*;
#(
    parameter int W     = xmss_pkg::W,
    parameter int IDX_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [255:0]       x_in,
    input  logic [IDX_W-1:0]   start_idx,
    input  logic [IDX_W-1:0]   steps,
    input  logic [255:0]       pub_seed,
    input  logic [255:0]       adrs,
    output logic [255:0]       data_out,
    output logic               data_out_valid,
    output logic               done,
    output logic               busy,
    output logic               hash_start,
    output logic               hash_init_iv,
    output logic [1023:0]      hash_data_in,
    output logic               hash_message_length,
    output logic               hash_second_block_data_available,
    output logic               hash_store_intermediate,
    output logic               hash_continue_intermediate,
    input  logic [255:0]       hash_data_out,
    input  logic               hash_done,
    input  logic               hash_busy
);

    chain_state_e      state_q, state_d;
    logic [255:0]      tmp_q, seed_q, adrs_q, key_q, bm_q, data_out_q;
    logic [IDX_W-1:0]  idx_q, rem_q;
    logic              done_q, valid_q, busy_q;

    logic [IDX_W-1:0]  room_s, eff_steps_s;
    logic              hash_start_s;
    msg_type_e         msg_type_s;
    logic [31:0]       kam_s;

    // start_idx never exceeds W-1, so the remaining room cannot underflow
    assign room_s      = IDX_W'(W - 1) - start_idx;
    assign eff_steps_s = (steps < room_s) ? steps : room_s;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, hash request strobe and message selection.
    // The message is a function of state only, so it stays stable from the
    // REQ cycle until the matching hash_done.
    always_comb begin
        state_d      = state_q;
        hash_start_s = 1'b0;
        msg_type_s   = MSG_NONE;
        kam_s        = KAM_KEY;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (eff_steps_s == {IDX_W{1'b0}}) ? ST_DONE : ST_KEY_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_KEY_REQ: begin
                msg_type_s = MSG_PRF;
                kam_s      = KAM_KEY;
                if (!hash_busy) begin
                    hash_start_s = 1'b1;
                    state_d      = ST_KEY_WAIT;
                end else begin
                    state_d = ST_KEY_REQ;
                end
            end
            ST_KEY_WAIT: begin
                msg_type_s = MSG_PRF;
                kam_s      = KAM_KEY;
                if (hash_done) begin
                    state_d = ST_BM_REQ;
                end else begin
                    state_d = ST_KEY_WAIT;
                end
            end
            ST_BM_REQ: begin
                msg_type_s = MSG_PRF;
                kam_s      = KAM_MASK;
                if (!hash_busy) begin
                    hash_start_s = 1'b1;
                    state_d      = ST_BM_WAIT;
                end else begin
                    state_d = ST_BM_REQ;
                end
            end
            ST_BM_WAIT: begin
                msg_type_s = MSG_PRF;
                kam_s      = KAM_MASK;
                if (hash_done) begin
                    state_d = ST_F_REQ;
                end else begin
                    state_d = ST_BM_WAIT;
                end
            end
            ST_F_REQ: begin
                msg_type_s = MSG_F;
                if (!hash_busy) begin
                    hash_start_s = 1'b1;
                    state_d      = ST_F_WAIT;
                end else begin
                    state_d = ST_F_REQ;
                end
            end
            ST_F_WAIT: begin
                msg_type_s = MSG_F;
                if (hash_done) begin
                    state_d = (rem_q == IDX_W'(1)) ? ST_DONE : ST_KEY_REQ;
                end else begin
                    state_d = ST_F_WAIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Operand capture, digest capture and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            tmp_q      <= 256'd0;
            seed_q     <= 256'd0;
            adrs_q     <= 256'd0;
            key_q      <= 256'd0;
            bm_q       <= 256'd0;
            data_out_q <= 256'd0;
            idx_q      <= {IDX_W{1'b0}};
            rem_q      <= {IDX_W{1'b0}};
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if ((state_q == ST_IDLE) && start) begin
                tmp_q   <= x_in;
                idx_q   <= start_idx;
                seed_q  <= pub_seed;
                adrs_q  <= adrs;
                rem_q   <= eff_steps_s;
                valid_q <= 1'b0;
                busy_q  <= 1'b1;
            end
            if ((state_q == ST_KEY_WAIT) && hash_done) begin
                key_q <= hash_data_out;
            end
            if ((state_q == ST_BM_WAIT) && hash_done) begin
                bm_q <= hash_data_out;
            end
            if ((state_q == ST_F_WAIT) && hash_done) begin
                tmp_q <= hash_data_out;
                idx_q <= idx_q + IDX_W'(1);
                rem_q <= rem_q - IDX_W'(1);
            end
            if (state_q == ST_DONE) begin
                data_out_q <= tmp_q;
                done_q     <= 1'b1;
                valid_q    <= 1'b1;
                busy_q     <= 1'b0;
            end
        end
    end

    wots_msg_fmt #(
        .IDX_W (IDX_W)
    ) u_msg_fmt (
        .msg_type_i     (msg_type_s),
        .idx_i          (idx_q),
        .key_and_mask_i (kam_s),
        .seed_i         (seed_q),
        .adrs_i         (adrs_q),
        .key_i          (key_q),
        .bm_i           (bm_q),
        .tmp_i          (tmp_q),
        .hash_data_in_o (hash_data_in)
    );

    assign data_out                         = data_out_q;
    assign data_out_valid                   = valid_q;
    assign done                             = done_q;
    assign busy                             = busy_q;
    assign hash_start                       = hash_start_s;
    assign hash_init_iv                     = hash_start_s;
    assign hash_message_length              = MSG_LEN_768;
    assign hash_second_block_data_available = 1'b1;
    assign hash_store_intermediate          = 1'b0;
    assign hash_continue_intermediate       = 1'b0;

endmodule
